// File: rtl/pcm_16qam.sv
// Payload constellation mapper: packs serial payload bits into 4-bit groups,
// maps each to a Gray-coded 16QAM point and queues it in a FWFT output FIFO.
module pcm_16qam #(
  parameter int UNIT  = 1024,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               di,
  input  logic               di_vld,
  input  logic               di_last,
  output logic               di_rdy,
  output logic signed [13:0] do_re,
  output logic signed [13:0] do_im,
  output logic               do_vld,
  output logic               do_last,
  input  logic               do_rdy,
  output logic [15:0]        sym_cnt
);

  localparam logic signed [13:0] LVL1 = 14'(UNIT);
  localparam logic signed [13:0] LVL3 = 14'(3 * UNIT);

  // 802.11a Gray mapping of one bit pair {first, second} to an axis level
  function automatic logic signed [13:0] gray_level(input logic [1:0] pair);
    case (pair)
      2'b00:   return -LVL3;
      2'b01:   return -LVL1;
      2'b11:   return LVL1;
      default: return LVL3;
    endcase
  endfunction

  logic [1:0]    phase;
  logic [2:0]    held;
  logic [3:0]    grp;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   count;
  logic [28:0]   mem [DEPTH];
  logic [28:0]   entry;
  logic [28:0]   head;
  logic          accept;
  logic          push;
  logic          pop;

  assign count  = wr_ptr - rd_ptr;
  assign di_rdy = rst & (count < (AW + 1)'(DEPTH));
  assign do_vld = (count != '0);
  assign accept = di_vld & di_rdy;
  assign push   = accept & ((phase == 2'd3) | di_last);
  assign pop    = do_vld & do_rdy;

  // grp[k] is bit bk of the group; positions beyond the current phase pad to 0
  always_comb begin
    grp = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      if (k < 32'(phase)) grp[k] = held[k];
    end
    grp[phase] = di;
  end

  assign entry = {di_last, gray_level({grp[0], grp[1]}), gray_level({grp[2], grp[3]})};
  assign head  = mem[rd_ptr[AW-1:0]];

  assign do_last = do_vld & head[28];
  assign do_re   = do_vld ? head[27:14] : '0;
  assign do_im   = do_vld ? head[13:0]  : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
      held  <= '0;
    end else if (accept) begin
      if (push) begin
        phase <= '0;
      end else begin
        phase <= phase + 2'd1;
        for (int unsigned k = 0; k < 3; k++) begin
          if (k == 32'(phase)) held[k] <= di;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_cnt <= '0;
    end else if (pop) begin
      if (head[28])              sym_cnt <= '0;
      else if (sym_cnt != '1)    sym_cnt <= sym_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pcm_16qam.sv
// Scoreboard bench for pcm_16qam: driver pushes expected symbols, monitor pops and compares.
module tb_pcm_16qam;

  localparam int UNIT  = 1024;
  localparam int DEPTH = 8;

  logic               clk;
  logic               rst;
  logic               di;
  logic               di_vld;
  logic               di_last;
  logic               di_rdy;
  logic signed [13:0] do_re;
  logic signed [13:0] do_im;
  logic               do_vld;
  logic               do_last;
  logic               do_rdy;
  logic [15:0]        sym_cnt;

  pcm_16qam #(.UNIT(UNIT), .DEPTH(DEPTH), .AW(3)) dut (
    .clk(clk), .rst(rst), .di(di), .di_vld(di_vld), .di_last(di_last),
    .di_rdy(di_rdy), .do_re(do_re), .do_im(do_im), .do_vld(do_vld),
    .do_last(do_last), .do_rdy(do_rdy), .sym_cnt(sym_cnt)
  );

  typedef struct {
    int re;
    int im;
    bit last;
  } sym_t;

  sym_t exp_q[$];
  bit   grp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   mdl_cnt  = 0;
  bit   rand_rdy = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int level(input bit hi, input bit lo);
    int tbl[4] = '{-3, -1, 3, 1};
    return tbl[{hi, lo}] * UNIT;
  endfunction

  task automatic model_accept(input bit b, input bit l);
    sym_t s;
    grp_q.push_back(b);
    if (grp_q.size() == 4 || l) begin
      while (grp_q.size() < 4) grp_q.push_back(1'b0);
      s.re   = level(grp_q[0], grp_q[1]);
      s.im   = level(grp_q[2], grp_q[3]);
      s.last = l;
      exp_q.push_back(s);
      grp_q.delete();
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send_bit(input bit b, input bit l);
    int n = 0;
    di = b; di_last = l; di_vld = 1'b1;
    while (!di_rdy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!di_rdy) chk("di_rdy_timeout", 0, 1);
    else model_accept(b, l);
    @(negedge clk);
    di_vld = 1'b0; di_last = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || do_vld) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rand_rdy) do_rdy = ($urandom_range(0, 9) < 7);
  end

  // Monitor samples 2 time units after the falling edge, once inputs have settled.
  always @(negedge clk) begin
    sym_t h;
    #2;
    if (rst) begin
      chk("sym_cnt", sym_cnt, mdl_cnt);
      if (do_vld) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_sym", 1, 0);
        end else begin
          h = exp_q[0];
          chk("do_re", do_re, h.re);
          chk("do_im", do_im, h.im);
          chk("do_last", do_last, h.last);
          if (do_rdy) begin
            void'(exp_q.pop_front());
            mdl_cnt = h.last ? 0 : ((mdl_cnt == 65535) ? 65535 : mdl_cnt + 1);
          end
        end
      end else begin
        chk("idle_zero", int'({do_re, do_im, do_last}), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    rst = 0; di = 0; di_vld = 0; di_last = 0; do_rdy = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_di_rdy", di_rdy, 0);
    chk("rst_do_vld", do_vld, 0);
    chk("rst_sym_cnt", sym_cnt, 0);
    chk("rst_out", int'({do_re, do_im, do_last}), 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);

    // single group 1,0,1,1 and first-symbol latency
    send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(1, 1);
    #1;
    chk("lat_do_vld", do_vld, 1);
    chk("single_re", do_re, 3 * UNIT);
    chk("single_im", do_im, UNIT);
    chk("single_last", do_last, 1);
    @(negedge clk);
    do_rdy = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("single_cnt", sym_cnt, 0);
    chk("single_empty", do_vld, 0);

    // all 16 groups in order, b0 first
    for (int g = 0; g < 16; g++)
      for (int k = 3; k >= 0; k--)
        send_bit(g[k], (g == 15) && (k == 0));
    drain();

    // padded 6-bit frame
    send_bit(1, 0); send_bit(1, 0); send_bit(0, 0); send_bit(1, 0);
    send_bit(0, 0); send_bit(1, 1);
    drain();

    // single-bit frame
    send_bit(1, 1);
    drain();

    // backpressure: fill the FIFO, then release while the next bit waits
    do_rdy = 0;
    for (int i = 0; i < 32; i++) send_bit($urandom_range(0, 1), 0);
    #1;
    chk("full_di_rdy", di_rdy, 0);
    chk("full_do_vld", do_vld, 1);
    fork
      for (int i = 0; i < 8; i++) send_bit($urandom_range(0, 1), i == 7);
      begin
        repeat (4) @(negedge clk);
        #1;
        chk("full_hold_di_rdy", di_rdy, 0);
        @(negedge clk);
        do_rdy = 1;
      end
    join
    drain();

    // reset mid-operation
    do_rdy = 0;
    for (int i = 0; i < 12; i++) send_bit(1, 0);
    do_rdy = 1;
    @(negedge clk);
    do_rdy = 0;
    send_bit(1, 0); send_bit(1, 0);
    #1;
    rst = 0;
    exp_q.delete(); grp_q.delete(); mdl_cnt = 0;
    #1;
    chk("mid_rst_do_vld", do_vld, 0);
    chk("mid_rst_sym_cnt", sym_cnt, 0);
    chk("mid_rst_di_rdy", di_rdy, 0);
    @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("post_rst_idle", do_vld, 0);
    @(negedge clk);
    send_bit(0, 0); send_bit(0, 0); send_bit(0, 0); send_bit(0, 1);
    #1;
    chk("post_rst_re", do_re, -3 * UNIT);
    chk("post_rst_im", do_im, -3 * UNIT);
    @(negedge clk);
    do_rdy = 1;
    drain();

    // randomized frames with gaps and random backpressure
    rand_rdy = 1;
    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        send_bit($urandom_range(0, 1), i == len - 1);
      end
    end
    @(negedge clk);
    rand_rdy = 0;
    do_rdy = 1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
